// File: rtl/pw_pkg.sv
/******************************************************************************
 * Module : pw_pkg
 * Shared types and helpers for the chunked password verifier.
 * Rev    : 1.0
 ******************************************************************************/
`default_nettype none

package pw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMP    = 2'd1,
        ST_RESULT = 2'd2,
        ST_LOCKED = 2'd3
    } pw_state_t;

    function automatic int chunk_width(input int digit_w, input int chunk_digits);
        return digit_w * chunk_digits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pw_chunk_cmp.sv
/******************************************************************************
 * Module : pw_chunk_cmp
 * Combinational inequality of one selected chunk of two code vectors.
 * Rev    : 1.0
 ******************************************************************************/
`default_nettype none

module pw_chunk_cmp
    import pw_pkg::*;
#(
    parameter int DIGIT_W      = 4,
    parameter int NUM_DIGITS   = 32,
    parameter int CHUNK_DIGITS = 8,
    parameter int IDX_W        = 2
) (
    input  logic [DIGIT_W*NUM_DIGITS-1:0] a,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] b,
    input  logic [IDX_W-1:0]              idx,
    output logic                          neq
);

    localparam int CW    = chunk_width(DIGIT_W, CHUNK_DIGITS);
    localparam int C     = NUM_DIGITS / CHUNK_DIGITS;
    localparam int SLOTS = 1 << IDX_W;

    // Padded to a power of two so every index value selects a defined bit.
    logic [SLOTS-1:0] neq_vec;

    for (genvar i = 0; i < SLOTS; i++) begin : g_chunk
        if (i < C) begin : g_live
            assign neq_vec[i] = (a[i*CW +: CW] != b[i*CW +: CW]);
        end else begin : g_pad
            assign neq_vec[i] = 1'b0;
        end
    end

    assign neq = neq_vec[idx];

endmodule

`default_nettype wire

// File: rtl/password_verifier.sv
/******************************************************************************
 * Module : password_verifier
 * Sequential chunked user/master password compare with failure lockout.
 * Rev    : 1.0
 ******************************************************************************/
`default_nettype none

module password_verifier
    import pw_pkg::*;
#(
    parameter int DIGIT_W      = 4,
    parameter int NUM_DIGITS   = 32,
    parameter int CHUNK_DIGITS = 8,
    parameter int MAX_FAIL     = 3,
    parameter int LOCK_CYCLES  = 1000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]    input_value,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]    ans,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]    master_ans,
    output logic                             ready,
    output logic                             done,
    output logic                             same,
    output logic                             master_same,
    output logic                             locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_count
);

    localparam int CODE_W = DIGIT_W * NUM_DIGITS;
    localparam int C      = NUM_DIGITS / CHUNK_DIGITS;
    localparam int IDX_W  = (C > 1) ? $clog2(C) : 1;
    localparam int FC_W   = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(C - 1);
    localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(MAX_FAIL);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(MAX_FAIL - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOCK_CYCLES - 1);

    pw_state_t         state_q, state_d;
    logic [CODE_W-1:0] in_q, in_d, ans_q, ans_d, mst_q, mst_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              user_miss_q, user_miss_d, master_miss_q, master_miss_d;
    logic              lock_mode_q, lock_mode_d;
    logic              ready_q, ready_d, done_q, done_d;
    logic              same_q, same_d, master_same_q, master_same_d;
    logic              locked_q, locked_d;
    logic [FC_W-1:0]   fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic user_neq, master_neq;
    logic u_miss_now, m_miss_now, hit_u, hit_m, expire;

    pw_chunk_cmp #(
        .DIGIT_W(DIGIT_W), .NUM_DIGITS(NUM_DIGITS), .CHUNK_DIGITS(CHUNK_DIGITS), .IDX_W(IDX_W)
    ) u_cmp_user (
        .a(in_q), .b(ans_q), .idx(idx_q), .neq(user_neq)
    );

    pw_chunk_cmp #(
        .DIGIT_W(DIGIT_W), .NUM_DIGITS(NUM_DIGITS), .CHUNK_DIGITS(CHUNK_DIGITS), .IDX_W(IDX_W)
    ) u_cmp_master (
        .a(in_q), .b(mst_q), .idx(idx_q), .neq(master_neq)
    );

    always_comb begin
        state_d       = state_q;
        in_d          = in_q;
        ans_d         = ans_q;
        mst_d         = mst_q;
        idx_d         = idx_q;
        user_miss_d   = user_miss_q;
        master_miss_d = master_miss_q;
        lock_mode_d   = lock_mode_q;
        done_d        = 1'b0;
        same_d        = same_q;
        master_same_d = master_same_q;
        locked_d      = locked_q;
        fail_d        = fail_q;
        timer_d       = timer_q;

        u_miss_now = user_miss_q | user_neq;
        m_miss_now = master_miss_q | master_neq;
        hit_u      = ~u_miss_now & ~lock_mode_q;
        hit_m      = ~m_miss_now;
        expire     = locked_q && (timer_q == '0);

        // The lock timer runs regardless of state, so in-flight compares keep it counting.
        if (locked_q) begin
            if (expire) begin
                locked_d = 1'b0;
                fail_d   = '0;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_LOCKED: begin
                if (start && ready_q) begin
                    in_d          = input_value;
                    ans_d         = ans;
                    mst_d         = master_ans;
                    same_d        = 1'b0;
                    master_same_d = 1'b0;
                    user_miss_d   = 1'b0;
                    master_miss_d = 1'b0;
                    idx_d         = '0;
                    lock_mode_d   = (state_q == ST_LOCKED);
                    state_d       = ST_CMP;
                end else if (state_q == ST_LOCKED && !locked_d) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMP: begin
                user_miss_d   = u_miss_now;
                master_miss_d = m_miss_now;
                idx_d         = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d         = '0;
                    state_d       = ST_RESULT;
                    done_d        = 1'b1;
                    same_d        = hit_u;
                    master_same_d = hit_m;
                    if (hit_u || hit_m) begin
                        fail_d   = '0;
                        locked_d = 1'b0;
                    end else if (!lock_mode_q) begin
                        if (fail_q == FC_LAST) begin
                            fail_d   = FC_MAX;
                            locked_d = 1'b1;
                            timer_d  = TMR_LOAD;
                        end else if (fail_q < FC_MAX) begin
                            fail_d = fail_q + 1'b1;
                        end
                    end
                end
            end
            ST_RESULT: begin
                state_d = locked_d ? ST_LOCKED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            in_q          <= '0;
            ans_q         <= '0;
            mst_q         <= '0;
            idx_q         <= '0;
            user_miss_q   <= 1'b0;
            master_miss_q <= 1'b0;
            lock_mode_q   <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            same_q        <= 1'b0;
            master_same_q <= 1'b0;
            locked_q      <= 1'b0;
            fail_q        <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            in_q          <= in_d;
            ans_q         <= ans_d;
            mst_q         <= mst_d;
            idx_q         <= idx_d;
            user_miss_q   <= user_miss_d;
            master_miss_q <= master_miss_d;
            lock_mode_q   <= lock_mode_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            same_q        <= same_d;
            master_same_q <= master_same_d;
            locked_q      <= locked_d;
            fail_q        <= fail_d;
            timer_q       <= timer_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign same        = same_q;
    assign master_same = master_same_q;
    assign locked      = locked_q;
    assign fail_count  = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_password_verifier.sv
/******************************************************************************
 * Module : tb_password_verifier
 * Directed self-checking bench for password_verifier (LOCK_CYCLES = 10).
 * Rev    : 1.0
 ******************************************************************************/
`default_nettype none

module tb_password_verifier;

    localparam logic [127:0] CODE_A = 128'h1234;
    localparam logic [127:0] WRONG  = 128'h9999;
    localparam logic [127:0] MASTER = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] input_value = '0;
    logic [127:0] ans = '0;
    logic [127:0] master_ans = '0;
    logic         ready, done, same, master_same, locked;
    logic [1:0]   fail_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat;

    password_verifier #(.LOCK_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .input_value(input_value), .ans(ans), .master_ans(master_ans),
        .ready(ready), .done(done), .same(same), .master_same(master_same),
        .locked(locked), .fail_count(fail_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge where done is seen (or on timeout).
    task automatic run_compare(input logic [127:0] iv, input logic [127:0] a,
                               input logic [127:0] m, output int l);
        input_value = iv; ans = a; master_ans = m; start = 1'b1; l = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            l++;
        end while (done !== 1'b1 && l < 40);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_timeout: done=%b want 1", done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
        checks++; if ({done, same, master_same, locked} !== 4'b0000) begin errors++;
            $display("FAIL rst_flags: got %b want 0000", {done, same, master_same, locked}); end
        checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL rst_fail: got %0d want 0", fail_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_match();
        run_compare(CODE_A, CODE_A, MASTER, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL match_latency: got %0d want 5", lat); end
        checks++; if (same !== 1'b1) begin errors++; $display("FAIL match_same: got %b want 1", same); end
        checks++; if (master_same !== 1'b0) begin errors++; $display("FAIL match_master: got %b want 0", master_same); end
        checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL match_fail: got %0d want 0", fail_count); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL match_ready_result: got %b want 0", ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL match_done_pulse: got %b want 0", done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL match_ready_idle: got %b want 1", ready); end
        checks++; if (same !== 1'b1) begin errors++; $display("FAIL match_same_held: got %b want 1", same); end
    endtask

    task automatic test_last_chunk();
        logic [127:0] iv;
        iv = CODE_A ^ (128'h1 << 124);
        run_compare(iv, CODE_A, MASTER, lat);
        checks++; if (same !== 1'b0) begin errors++; $display("FAIL last_same: got %b want 0", same); end
        checks++; if (master_same !== 1'b0) begin errors++; $display("FAIL last_master: got %b want 0", master_same); end
        checks++; if (fail_count !== 2'd1) begin errors++; $display("FAIL last_fail: got %0d want 1", fail_count); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL last_locked: got %b want 0", locked); end
        @(negedge clk);
    endtask

    task automatic test_lockout();
        int lk;
        run_compare(WRONG, CODE_A, MASTER, lat);
        checks++; if (fail_count !== 2'd2 || locked !== 1'b0) begin errors++;
            $display("FAIL lock_second: fail=%0d locked=%b want 2,0", fail_count, locked); end
        @(negedge clk);
        run_compare(WRONG, CODE_A, MASTER, lat);
        lk = cyc;
        checks++; if (fail_count !== 2'd3 || locked !== 1'b1) begin errors++;
            $display("FAIL lock_third: fail=%0d locked=%b want 3,1", fail_count, locked); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lock_ready: got %b want 1", ready); end
        run_compare(CODE_A, CODE_A, MASTER, lat);
        checks++; if (same !== 1'b0) begin errors++; $display("FAIL lock_user_same: got %b want 0", same); end
        checks++; if (locked !== 1'b1 || fail_count !== 2'd3) begin errors++;
            $display("FAIL lock_user_state: locked=%b fail=%0d want 1,3", locked, fail_count); end
        while (cyc < lk + 9) @(negedge clk);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_before_expiry: got %b want 1", locked); end
        @(negedge clk);
        checks++; if (locked !== 1'b0 || fail_count !== 2'd0) begin errors++;
            $display("FAIL lock_expiry: locked=%b fail=%0d want 0,0", locked, fail_count); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lock_expiry_ready: got %b want 1", ready); end
        @(negedge clk);
    endtask

    task automatic test_master_unlock();
        for (int i = 0; i < 3; i++) begin
            run_compare(WRONG, CODE_A, MASTER, lat);
            @(negedge clk);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mst_prelock: got %b want 1", locked); end
        run_compare(MASTER, CODE_A, MASTER, lat);
        checks++; if (master_same !== 1'b1) begin errors++; $display("FAIL mst_same: got %b want 1", master_same); end
        checks++; if (same !== 1'b0) begin errors++; $display("FAIL mst_user_same: got %b want 0", same); end
        checks++; if (locked !== 1'b0 || fail_count !== 2'd0) begin errors++;
            $display("FAIL mst_unlock: locked=%b fail=%0d want 0,0", locked, fail_count); end
        @(negedge clk);
        checks++; if (ready !== 1'b1 || locked !== 1'b0) begin errors++;
            $display("FAIL mst_after: ready=%b locked=%b want 1,0", ready, locked); end
    endtask

    task automatic test_ignore_during_cmp();
        int extra;
        input_value = CODE_A; ans = CODE_A; master_ans = MASTER; start = 1'b1; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            input_value = WRONG; ans = WRONG; master_ans = WRONG;
            if (lat == 3) start = 1'b0;
        end while (done !== 1'b1 && lat < 40);
        start = 1'b0;
        checks++; if (lat != 5) begin errors++; $display("FAIL ign_latency: got %0d want 5", lat); end
        checks++; if (same !== 1'b1 || master_same !== 1'b0) begin errors++;
            $display("FAIL ign_result: same=%b master=%b want 1,0", same, master_same); end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ign_no_queue: extra done=%0d want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int seen;
        run_compare(WRONG, CODE_A, MASTER, lat);
        @(negedge clk);
        input_value = WRONG; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({done, same, master_same, locked} !== 4'b0000 || fail_count !== 2'd0) begin errors++;
            $display("FAIL rmid_cmp: flags=%b fail=%0d want 0000,0", {done, same, master_same, locked}, fail_count); end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_done: got %0d want 0", seen); end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            run_compare(WRONG, CODE_A, MASTER, lat);
            @(negedge clk);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rmid_prelock: got %b want 1", locked); end
        rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0 || fail_count !== 2'd0 || ready !== 1'b1) begin errors++;
            $display("FAIL rmid_lock: locked=%b fail=%0d ready=%b want 0,0,1", locked, fail_count, ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_compare(CODE_A, CODE_A, MASTER, lat);
        checks++; if (lat != 5 || same !== 1'b1 || fail_count !== 2'd0) begin errors++;
            $display("FAIL rmid_after: lat=%0d same=%b fail=%0d want 5,1,0", lat, same, fail_count); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_match();
        test_last_chunk();
        test_lockout();
        test_master_unlock();
        test_ignore_during_cmp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
